// File: rtl/counter_pkg.sv
// Shared definitions for the golden 32-bit up/down counter: mode encodings and sizing.
package counter_pkg;
  localparam int WIDTH    = 32;
  localparam int STEP_BIG = 3;

  typedef enum logic [1:0] {
    MODE_UP1  = 2'b00,
    MODE_DN1  = 2'b01,
    MODE_DN3  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;
endpackage

// File: rtl/counter_next_state.sv
// Combinational next-state logic: next count value, wrap flag and load flag for one enabled cycle.
module counter_next_state
  import counter_pkg::*;
#(
  parameter int W    = WIDTH,
  parameter int STEP = STEP_BIG
) (
  input  logic [W-1:0] q,
  input  logic [1:0]   mode,
  input  logic [W-1:0] d,
  output logic [W-1:0] next_q,
  output logic         wrap,
  output logic         is_load
);
  localparam logic [W:0] ONE_EXT  = (W+1)'(1);
  localparam logic [W:0] STEP_EXT = (W+1)'(STEP);

  logic [W:0] q_ext;
  logic [W:0] res_ext;

  assign q_ext = {1'b0, q};

  // The extra MSB of the W+1 result is the carry (up) or borrow (down), i.e. the wrap flag.
  always_comb begin
    res_ext = q_ext;
    next_q  = q;
    wrap    = 1'b0;
    is_load = 1'b0;
    case (mode)
      MODE_UP1: begin
        res_ext = q_ext + ONE_EXT;
        next_q  = res_ext[W-1:0];
        wrap    = res_ext[W];
      end
      MODE_DN1: begin
        res_ext = q_ext - ONE_EXT;
        next_q  = res_ext[W-1:0];
        wrap    = res_ext[W];
      end
      MODE_DN3: begin
        res_ext = q_ext - STEP_EXT;
        next_q  = res_ext[W-1:0];
        wrap    = res_ext[W];
      end
      MODE_LOAD: begin
        next_q  = d;
        is_load = 1'b1;
      end
      default: begin
        next_q  = q;
        wrap    = 1'b0;
        is_load = 1'b0;
      end
    endcase
  end
endmodule

// File: rtl/scoreboard_counter32.sv
// Golden reference counter: async active-low reset registers plus enable gating around the
// combinational next-state block. Q, rco and load are all registered.
module scoreboard_counter32
  import counter_pkg::*;
#(
  parameter int WIDTH_P    = WIDTH,
  parameter int STEP_BIG_P = STEP_BIG
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable_,
  input  logic [1:0]         mode_sb32,
  input  logic [WIDTH_P-1:0] D_sb32,
  output logic [WIDTH_P-1:0] Q_sb32,
  output logic               rco_sb32,
  output logic               load_sb32
);
  logic [WIDTH_P-1:0] q_q, q_d;
  logic               rco_q, rco_d;
  logic               load_q, load_d;
  logic [WIDTH_P-1:0] next_q;
  logic               wrap;
  logic               is_load;

  counter_next_state #(
    .W    (WIDTH_P),
    .STEP (STEP_BIG_P)
  ) u_next (
    .q       (q_q),
    .mode    (mode_sb32),
    .d       (D_sb32),
    .next_q  (next_q),
    .wrap    (wrap),
    .is_load (is_load)
  );

  // Pulses are recomputed every cycle, so they drop on any idle cycle.
  always_comb begin
    q_d    = q_q;
    rco_d  = 1'b0;
    load_d = 1'b0;
    if (enable_) begin
      q_d    = next_q;
      rco_d  = wrap;
      load_d = is_load;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q    <= '0;
      rco_q  <= 1'b0;
      load_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      rco_q  <= rco_d;
      load_q <= load_d;
    end
  end

  assign Q_sb32    = q_q;
  assign rco_sb32  = rco_q;
  assign load_sb32 = load_q;
endmodule

// File: tb/tb_scoreboard_counter32.sv
// Directed and random checks of the golden 32-bit counter against hand-computed values
// and an independent modulo-2^32 model.
module tb_scoreboard_counter32;
  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         enable_;
  logic [1:0]   mode_sb32;
  logic [W-1:0] D_sb32;
  logic [W-1:0] Q_sb32;
  logic         rco_sb32;
  logic         load_sb32;

  int total;
  int bad;

  logic [W+1:0] exp_q[$];

  scoreboard_counter32 dut (
    .clk       (clk),
    .reset     (reset),
    .enable_   (enable_),
    .mode_sb32 (mode_sb32),
    .D_sb32    (D_sb32),
    .Q_sb32    (Q_sb32),
    .rco_sb32  (rco_sb32),
    .load_sb32 (load_sb32)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive(input logic en, input logic [1:0] mode, input logic [W-1:0] d);
    enable_   = en;
    mode_sb32 = mode;
    D_sb32    = d;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [W+1:0] obs;
    cycle();
    cycle();
    obs = {Q_sb32, rco_sb32, load_sb32};
    total++;
    if (obs !== {32'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_init: got %h want %h", obs, {32'h0, 2'b00});
    end
    reset = 1'b1;
    drive(1'b1, 2'b11, 32'h1234);
    cycle();
    obs = {Q_sb32, rco_sb32, load_sb32};
    total++;
    if (obs !== {32'h1234, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_first_load: got %h want %h", obs, {32'h1234, 2'b01});
    end
    drive(1'b1, 2'b00, 32'h0);
    #2;
    reset = 1'b0;
    #1;
    obs = {Q_sb32, rco_sb32, load_sb32};
    total++;
    if (obs !== {32'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_async: got %h want %h", obs, {32'h0, 2'b00});
    end
    cycle();
    obs = {Q_sb32, rco_sb32, load_sb32};
    total++;
    if (obs !== {32'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_held: got %h want %h", obs, {32'h0, 2'b00});
    end
    reset = 1'b1;
    cycle();
    obs = {Q_sb32, rco_sb32, load_sb32};
    total++;
    if (obs !== {32'h1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_release_first_edge: got %h want %h", obs, {32'h1, 2'b00});
    end
  endtask

  task automatic test_load_up();
    logic [W+1:0] obs;
    drive(1'b1, 2'b11, 32'hFFFF_FFFE);
    cycle();
    obs = {Q_sb32, rco_sb32, load_sb32};
    total++;
    if (obs !== {32'hFFFF_FFFE, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL load_fffffffe: got %h want %h", obs, {32'hFFFF_FFFE, 2'b01});
    end
    drive(1'b1, 2'b00, 32'h0);
    cycle();
    obs = {Q_sb32, rco_sb32, load_sb32};
    total++;
    if (obs !== {32'hFFFF_FFFF, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL up_to_max: got %h want %h", obs, {32'hFFFF_FFFF, 2'b00});
    end
    cycle();
    obs = {Q_sb32, rco_sb32, load_sb32};
    total++;
    if (obs !== {32'h0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL up_wrap: got %h want %h", obs, {32'h0, 2'b10});
    end
    drive(1'b1, 2'b11, 32'hFFFF_FFFF);
    cycle();
    obs = {Q_sb32, rco_sb32, load_sb32};
    total++;
    if (obs !== {32'hFFFF_FFFF, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL load_max_no_rco: got %h want %h", obs, {32'hFFFF_FFFF, 2'b01});
    end
  endtask

  task automatic test_down1();
    logic [W+1:0] obs;
    drive(1'b1, 2'b11, 32'h1);
    cycle();
    obs = {Q_sb32, rco_sb32, load_sb32};
    total++;
    if (obs !== {32'h1, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL dn1_load: got %h want %h", obs, {32'h1, 2'b01});
    end
    drive(1'b1, 2'b01, 32'h0);
    cycle();
    obs = {Q_sb32, rco_sb32, load_sb32};
    total++;
    if (obs !== {32'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL dn1_to_zero: got %h want %h", obs, {32'h0, 2'b00});
    end
    cycle();
    obs = {Q_sb32, rco_sb32, load_sb32};
    total++;
    if (obs !== {32'hFFFF_FFFF, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL dn1_wrap: got %h want %h", obs, {32'hFFFF_FFFF, 2'b10});
    end
  endtask

  task automatic test_down3();
    logic [W+1:0] obs;
    drive(1'b1, 2'b11, 32'h2);
    cycle();
    drive(1'b1, 2'b10, 32'h0);
    cycle();
    obs = {Q_sb32, rco_sb32, load_sb32};
    total++;
    if (obs !== {32'hFFFF_FFFF, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL dn3_wrap_from_2: got %h want %h", obs, {32'hFFFF_FFFF, 2'b10});
    end
    cycle();
    obs = {Q_sb32, rco_sb32, load_sb32};
    total++;
    if (obs !== {32'hFFFF_FFFC, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL dn3_no_wrap: got %h want %h", obs, {32'hFFFF_FFFC, 2'b00});
    end
    drive(1'b1, 2'b11, 32'h3);
    cycle();
    drive(1'b1, 2'b10, 32'h0);
    cycle();
    obs = {Q_sb32, rco_sb32, load_sb32};
    total++;
    if (obs !== {32'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL dn3_3_to_0: got %h want %h", obs, {32'h0, 2'b00});
    end
    drive(1'b1, 2'b11, 32'h1);
    cycle();
    drive(1'b1, 2'b10, 32'h0);
    cycle();
    obs = {Q_sb32, rco_sb32, load_sb32};
    total++;
    if (obs !== {32'hFFFF_FFFE, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL dn3_1_wrap: got %h want %h", obs, {32'hFFFF_FFFE, 2'b10});
    end
  endtask

  task automatic test_hold();
    logic [W+1:0] obs;
    drive(1'b1, 2'b11, 32'h55);
    cycle();
    obs = {Q_sb32, rco_sb32, load_sb32};
    total++;
    if (obs !== {32'h55, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL hold_load: got %h want %h", obs, {32'h55, 2'b01});
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 2'($urandom_range(0, 3)), $urandom());
      cycle();
      obs = {Q_sb32, rco_sb32, load_sb32};
      total++;
      if (obs !== {32'h55, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL hold_cycle%0d: got %h want %h", i, obs, {32'h55, 2'b00});
      end
    end
  endtask

  // Independent modulo-2^32 model using 64-bit arithmetic, checked through exp_q.
  task automatic test_random();
    logic [W+1:0] obs;
    logic [W+1:0] exp_v;
    logic [W-1:0] m_q;
    logic [63:0]  wide;
    logic         m_rco;
    logic         m_load;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] d;
    drive(1'b1, 2'b11, 32'h0);
    cycle();
    m_q = 32'h0;
    for (int i = 0; i < 100; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      mode = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0:       d = 32'h0;
        1:       d = 32'hFFFF_FFFF;
        2:       d = 32'h1;
        3:       d = 32'h2;
        default: d = $urandom();
      endcase
      m_rco  = 1'b0;
      m_load = 1'b0;
      if (en) begin
        if (mode == 2'b00) begin
          wide  = {32'h0, m_q} + 64'd1;
          m_rco = (wide >= 64'h1_0000_0000);
          m_q   = wide[31:0];
        end else if (mode == 2'b01) begin
          m_rco = (m_q == 32'h0);
          wide  = {32'h0, m_q} + 64'hFFFF_FFFF;
          m_q   = wide[31:0];
        end else if (mode == 2'b10) begin
          m_rco = (m_q < 32'd3);
          wide  = {32'h0, m_q} + 64'h1_0000_0000 - 64'd3;
          m_q   = wide[31:0];
        end else begin
          m_load = 1'b1;
          m_q    = d;
        end
      end
      exp_q.push_back({m_q, m_rco, m_load});
      drive(en, mode, d);
      cycle();
      exp_v = exp_q.pop_front();
      obs   = {Q_sb32, rco_sb32, load_sb32};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL random_iter%0d (en=%0b mode=%0b d=%h): got %h want %h",
                 i, en, mode, d, obs, exp_v);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    drive(1'b0, 2'b00, 32'h0);
    test_reset();
    test_load_up();
    test_down1();
    test_down3();
    test_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
